// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the request handshake, the memory bus and the response handshake
// of the load/store unit into one bundle.
//   req_*  : request from the MEM stage (valid/ready handshake)
//   mem_*  : single-cycle memory port (strobes out, read data and fault back)
//   resp_* : in-order response to writeback (valid/ready handshake)
// Modports:
//   slave  : the load/store unit itself
//   master : whoever drives requests, models memory and consumes responses
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_base;
    logic [31:0]           req_offset;
    logic [31:0]           req_store_data;
    logic [4:0]            req_rd;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic                  mem_write;
    logic                  mem_read;
    logic [2:0]            mem_funct3;
    logic [31:0]           mem_data_out;
    logic                  mem_data_access_fault_exception;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [4:0]            resp_rd;
    logic                  resp_is_load;
    logic                  resp_fault;
    logic                  resp_illegal;
    logic [31:0]           resp_fault_addr;

    modport slave (
        input  req_valid, req_write, req_funct3, req_base, req_offset,
               req_store_data, req_rd,
        output req_ready,
        output mem_address, mem_data_in, mem_write, mem_read, mem_funct3,
        input  mem_data_out, mem_data_access_fault_exception,
        output resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
               resp_illegal, resp_fault_addr,
        input  resp_ready
    );

    modport master (
        output req_valid, req_write, req_funct3, req_base, req_offset,
               req_store_data, req_rd,
        input  req_ready,
        input  mem_address, mem_data_in, mem_write, mem_read, mem_funct3,
        output mem_data_out, mem_data_access_fault_exception,
        input  resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
               resp_illegal, resp_fault_addr,
        output resp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I load/store unit. Each accepted request is issued to memory in its
// accept cycle, tracked for one cycle in an in-flight register, then turned
// into a response (load extension, fault, illegal funct3) and queued in a
// 2-entry in-order FIFO that drives the response handshake.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   flush : drop every response not yet delivered
//   bus   : load_store_unit_if.slave (req_*, mem_*, resp_*)
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    load_store_unit_if.slave    bus
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_load;
        logic        fault;
        logic        illegal;
        logic [31:0] addr;
    } resp_t;

    logic [31:0] eff_addr;
    logic        legal;
    logic        accept;
    logic        issue;
    logic        pop;
    logic        push;
    logic        q_valid;
    logic [2:0]  occ_after;

    logic        f;
    logic [4:0]  f_rd;
    logic [2:0]  f_funct3;
    logic        f_is_load;
    logic        f_illegal;
    logic [31:0] f_addr;

    logic [1:0]  count;
    resp_t       ent0;
    resp_t       ent1;
    resp_t       new_resp;

    assign eff_addr = bus.req_base + bus.req_offset;

    always_comb begin
        legal = 1'b0;
        if (bus.req_write)
            legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    assign q_valid = (count != 2'd0);
    assign pop     = q_valid && bus.resp_ready;

    // Counting the in-flight request against the queue guarantees its slot
    // exists when the response lands next cycle.
    assign occ_after = {1'b0, count} + {2'b00, f} - {2'b00, pop};
    assign bus.req_ready = rst_n && !flush && (occ_after < 3'(RESP_DEPTH));

    assign accept = bus.req_valid && bus.req_ready;
    assign issue  = accept && legal;

    assign bus.mem_read    = issue && !bus.req_write;
    assign bus.mem_write   = issue && bus.req_write;
    assign bus.mem_address = issue ? eff_addr[ADDR_WIDTH-1:0] : '0;
    assign bus.mem_data_in = issue ? bus.req_store_data : 32'h0;
    assign bus.mem_funct3  = issue ? bus.req_funct3 : 3'b000;

    // Illegal requests never strobed memory, so any fault input is ignored.
    always_comb begin
        new_resp         = '0;
        new_resp.rd      = f_rd;
        new_resp.is_load = f_is_load;
        new_resp.illegal = f_illegal;
        new_resp.addr    = f_addr;
        new_resp.fault   = !f_illegal && bus.mem_data_access_fault_exception;
        if (f_is_load && !f_illegal && !new_resp.fault) begin
            case (f_funct3)
                3'b000:  new_resp.data = {{24{bus.mem_data_out[7]}}, bus.mem_data_out[7:0]};
                3'b001:  new_resp.data = {{16{bus.mem_data_out[15]}}, bus.mem_data_out[15:0]};
                default: new_resp.data = bus.mem_data_out;
            endcase
        end
    end

    assign push = f && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f         <= 1'b0;
            f_rd      <= '0;
            f_funct3  <= '0;
            f_is_load <= 1'b0;
            f_illegal <= 1'b0;
            f_addr    <= '0;
            count     <= '0;
            ent0      <= '0;
            ent1      <= '0;
        end else begin
            f <= accept;
            if (accept) begin
                f_rd      <= bus.req_rd;
                f_funct3  <= bus.req_funct3;
                f_is_load <= !bus.req_write;
                f_illegal <= !legal;
                f_addr    <= eff_addr;
            end
            if (flush) begin
                count <= '0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) ent0 <= new_resp;
                        else               ent1 <= new_resp;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        ent0  <= ent1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        // New entry queues behind the one being popped.
                        if (count == 2'd1) begin
                            ent0 <= new_resp;
                        end else begin
                            ent0 <= ent1;
                            ent1 <= new_resp;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs read as zero whenever the queue is empty, including after reset.
    assign bus.resp_valid      = q_valid;
    assign bus.resp_data       = q_valid ? ent0.data    : 32'h0;
    assign bus.resp_rd         = q_valid ? ent0.rd      : 5'd0;
    assign bus.resp_is_load    = q_valid && ent0.is_load;
    assign bus.resp_fault      = q_valid && ent0.fault;
    assign bus.resp_illegal    = q_valid && ent0.illegal;
    assign bus.resp_fault_addr = q_valid ? ent0.addr    : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit: a behavioural memory answers one cycle
// after each strobe, expected responses are queued when a request is
// accepted and compared when the unit delivers a response.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .RESP_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_load;
        logic        fault;
        logic        illegal;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  b2b_f3[4]   = '{3'b010, 3'b001, 3'b101, 3'b000};
    logic [31:0] b2b_base[4] = '{32'h0000_0100, 32'h0000_0204, 32'h0000_030A, 32'h0000_0413};
    logic [31:0] b2b_off[4]  = '{32'h0000_0004, 32'hFFFF_FFFE, 32'h0000_0008, 32'h0000_0001};
    logic [4:0]  b2b_rd[4]   = '{5'd7, 5'd8, 5'd9, 5'd10};

    localparam logic [31:0] FAULT_ADDR = 32'h0000_FFFE;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0000_0080;
        return {a[7:0], ~a[7:0], a[7:0] ^ 8'h81, a[7:0] | 8'h80};
    endfunction

    // Memory zero-extends sub-word reads.
    function automatic logic [31:0] mem_return(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] raw;
        raw = mem_model(a);
        case (f3)
            3'b000, 3'b100: return {24'h0, raw[7:0]};
            3'b001, 3'b101: return {16'h0, raw[15:0]};
            default:        return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.mem_data_out <= bus.mem_read ? mem_return(bus.mem_address, bus.mem_funct3) : 32'h0;
        bus.mem_data_access_fault_exception <= (bus.mem_read || bus.mem_write)
                                               && (bus.mem_address == FAULT_ADDR);
    end

    function automatic exp_t expect_resp(input logic w, input logic [2:0] f3,
                                         input logic [31:0] b, input logic [31:0] o,
                                         input logic [4:0] rd);
        exp_t        e;
        logic [31:0] ea;
        logic [31:0] raw;
        ea        = b + o;
        e.rd      = rd;
        e.is_load = !w;
        e.addr    = ea;
        e.illegal = w ? !(f3 inside {3'b000, 3'b001, 3'b010})
                      : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        e.fault   = !e.illegal && (ea == FAULT_ADDR);
        e.data    = 32'h0;
        if (!w && !e.illegal && !e.fault) begin
            raw = mem_return(ea, f3);
            case (f3)
                3'b000:  e.data = {{24{raw[7]}}, raw[7:0]};
                3'b001:  e.data = {{16{raw[15]}}, raw[15:0]};
                default: e.data = raw;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input logic [4:0] rd);
        bus.req_valid      = 1'b1;
        bus.req_write      = w;
        bus.req_funct3     = f3;
        bus.req_base       = b;
        bus.req_offset     = o;
        bus.req_store_data = sd;
        bus.req_rd         = rd;
    endtask

    task automatic idle();
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_funct3     = 3'b000;
        bus.req_base       = 32'h0;
        bus.req_offset     = 32'h0;
        bus.req_store_data = 32'h0;
        bus.req_rd         = 5'd0;
    endtask

    // Scoreboard bookkeeping for the current cycle, then move to the next negedge.
    task automatic advance();
        exp_t e;
        #1;
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_data",       bus.resp_data,               e.data);
                chk("sb_rd",         32'(bus.resp_rd),            32'(e.rd));
                chk("sb_is_load",    32'(bus.resp_is_load),       32'(e.is_load));
                chk("sb_fault",      32'(bus.resp_fault),         32'(e.fault));
                chk("sb_illegal",    32'(bus.resp_illegal),       32'(e.illegal));
                chk("sb_fault_addr", bus.resp_fault_addr,         e.addr);
            end
        end
        if (flush) sb.delete();
        if (rst_n && bus.req_valid && bus.req_ready)
            sb.push_back(expect_resp(bus.req_write, bus.req_funct3, bus.req_base,
                                     bus.req_offset, bus.req_rd));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.resp_ready = 1'b1;
        drive(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd1);

        // Reset: strobes and responses held low.
        @(negedge clk);
        #1;
        chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
        chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        advance();
        rst_n = 1'b1;
        idle();
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_mem_addr",  bus.mem_address,    32'h0);
        advance();

        // LB sign extension, then LBU of the same byte.
        drive(1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 5'd5);
        #1;
        chk("lb_mem_read", 32'(bus.mem_read), 32'd1);
        chk("lb_mem_addr", bus.mem_address,   32'h10);
        advance();
        idle();
        #1;
        chk("lb_lat1_valid", 32'(bus.resp_valid), 32'd0);
        advance();
        #1;
        chk("lb_valid",   32'(bus.resp_valid),   32'd1);
        chk("lb_data",    bus.resp_data,         32'hFFFF_FF80);
        chk("lb_is_load", 32'(bus.resp_is_load), 32'd1);
        chk("lb_addr",    bus.resp_fault_addr,   32'h10);
        advance();
        drive(1'b0, 3'b100, 32'h10, 32'h0, 32'h0, 5'd6);
        advance();
        idle();
        advance();
        #1;
        chk("lbu_data", bus.resp_data, 32'h0000_0080);
        advance();

        // Four back-to-back loads with resp_ready held high.
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b0, b2b_f3[c], b2b_base[c], b2b_off[c], 32'h0, b2b_rd[c]);
            else       idle();
            #1;
            if (c < 4) chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
            if (c >= 2 && c < 6) begin
                chk("b2b_valid", 32'(bus.resp_valid), 32'd1);
                chk("b2b_rd",    32'(bus.resp_rd),    32'(b2b_rd[c-2]));
            end else begin
                chk("b2b_idle_valid", 32'(bus.resp_valid), 32'd0);
            end
            advance();
        end

        // Backpressure: two accepted, third waits until the first pop.
        bus.resp_ready = 1'b0;
        drive(1'b0, 3'b001, 32'h200, 32'h7E, 32'h0, 5'd11);
        #1; chk("bp_ready_a", 32'(bus.req_ready), 32'd1);
        advance();
        drive(1'b0, 3'b100, 32'h300, 32'h5, 32'h0, 5'd12);
        #1; chk("bp_ready_b", 32'(bus.req_ready), 32'd1);
        advance();
        drive(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd13);
        #1;
        chk("bp_ready_c0", 32'(bus.req_ready),  32'd0);
        chk("bp_valid_a",  32'(bus.resp_valid), 32'd1);
        advance();
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_ready_full", 32'(bus.req_ready), 32'd0);
            chk("bp_hold_rd",    32'(bus.resp_rd),   32'd11);
            if (sb.size() != 0) chk("bp_hold_data", bus.resp_data, sb[0].data);
            advance();
        end
        bus.resp_ready = 1'b1;
        #1; chk("bp_ready_c1", 32'(bus.req_ready), 32'd1);
        advance();
        idle();
        #1; chk("bp_rd_b", 32'(bus.resp_rd), 32'd12);
        advance();
        #1;
        chk("bp_valid_c", 32'(bus.resp_valid), 32'd1);
        chk("bp_rd_c",    32'(bus.resp_rd),    32'd13);
        advance();

        // Faulting LW at an address formed by wraparound.
        drive(1'b0, 3'b010, 32'h0001_0000, 32'hFFFF_FFFE, 32'h0, 5'd14);
        #1; chk("flt_mem_addr", bus.mem_address, FAULT_ADDR);
        advance();
        idle();
        advance();
        #1;
        chk("flt_fault", 32'(bus.resp_fault), 32'd1);
        chk("flt_data",  bus.resp_data,       32'h0);
        chk("flt_addr",  bus.resp_fault_addr, FAULT_ADDR);
        advance();

        // Illegal load, legal store, illegal store.
        drive(1'b0, 3'b011, 32'h50, 32'h0, 32'h0, 5'd15);
        #1;
        chk("ill_ld_mem_read", 32'(bus.mem_read),  32'd0);
        chk("ill_ld_ready",    32'(bus.req_ready), 32'd1);
        advance();
        idle();
        advance();
        #1; chk("ill_ld_flag", 32'(bus.resp_illegal), 32'd1);
        advance();
        drive(1'b1, 3'b010, 32'h60, 32'h4, 32'hDEAD_BEEF, 5'd16);
        #1;
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        chk("sw_mem_data",  bus.mem_data_in,    32'hDEAD_BEEF);
        chk("sw_mem_addr",  bus.mem_address,    32'h64);
        advance();
        idle();
        #1; chk("idle_mem_data_in", bus.mem_data_in, 32'h0);
        advance();
        #1;
        chk("sw_is_load", 32'(bus.resp_is_load), 32'd0);
        chk("sw_data",    bus.resp_data,         32'h0);
        advance();
        drive(1'b1, 3'b100, 32'h70, 32'h0, 32'h1234_5678, 5'd17);
        #1; chk("ill_st_mem_write", 32'(bus.mem_write), 32'd0);
        advance();
        idle();
        advance();
        advance();

        // Flush with one in flight and one queued.
        bus.resp_ready = 1'b0;
        drive(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 5'd18);
        advance();
        drive(1'b0, 3'b010, 32'h704, 32'h0, 32'h0, 5'd19);
        advance();
        flush = 1'b1;
        drive(1'b0, 3'b010, 32'h708, 32'h0, 32'h0, 5'd20);
        #1;
        chk("fl_ready",    32'(bus.req_ready), 32'd0);
        chk("fl_mem_read", 32'(bus.mem_read),  32'd0);
        advance();
        flush = 1'b0;
        idle();
        #1; chk("fl_valid0", 32'(bus.resp_valid), 32'd0);
        advance();
        #1;
        chk("fl_valid1", 32'(bus.resp_valid), 32'd0);
        chk("fl_ready1", 32'(bus.req_ready),  32'd1);
        advance();

        // Reset with a full queue.
        drive(1'b0, 3'b101, 32'h800, 32'h2, 32'h0, 5'd21);
        advance();
        drive(1'b1, 3'b010, 32'h804, 32'h0, 32'hCAFE_F00D, 5'd22);
        advance();
        idle();
        advance();
        #1;
        chk("rf_valid_full", 32'(bus.resp_valid), 32'd1);
        chk("rf_ready_full", 32'(bus.req_ready),  32'd0);
        rst_n = 1'b0;
        advance();
        sb.delete();
        #1;
        chk("rf_valid",      32'(bus.resp_valid),   32'd0);
        chk("rf_data",       bus.resp_data,         32'h0);
        chk("rf_rd",         32'(bus.resp_rd),      32'd0);
        chk("rf_is_load",    32'(bus.resp_is_load), 32'd0);
        chk("rf_fault",      32'(bus.resp_fault),   32'd0);
        chk("rf_illegal",    32'(bus.resp_illegal), 32'd0);
        chk("rf_fault_addr", bus.resp_fault_addr,   32'h0);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        advance();
        drive(1'b0, 3'b001, 32'h900, 32'h2, 32'h0, 5'd23);
        #1; chk("rf_first_ready", 32'(bus.req_ready), 32'd1);
        advance();
        idle();

        // Drain whatever is still expected, bounded.
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            advance();
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
